avr_cpu_progmem_arb: RTL and testbench
======================================

# avr_cpu_progmem_arb

Arbiter and sequencer for the single-port, synchronous-read program memory.
- Shares one memory port between the instruction fetch unit (16-bit word reads) and the LPM execution path (8-bit byte reads via the Z pointer).
- Issues at most one memory access per cycle.
- Routes each 1-cycle-latency read response back to the requester that issued it.
- Bounds fetch starvation during back-to-back LPM traffic.

## Interface

Parameters:
- PROG_MEM_SIZE, 512, program memory depth in 16-bit words
- PROG_MEM_ADDR_WIDTH, $clog2(PROG_MEM_SIZE), memory address width
- LPM_BURST, 2, maximum consecutive LPM grants while fetch is waiting (range 1..15)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch requests a word read
- fetch_addr  in  16  fetch word address
- fetch_gnt  out  1  fetch access issued this cycle
- fetch_valid  out  1  fetch_data valid
- fetch_data  out  16  fetched instruction word
- lpm_req  in  1  LPM requests a byte read
- lpm_addr  in  16  LPM byte address (Z)
- lpm_gnt  out  1  LPM access issued this cycle
- lpm_valid  out  1  lpm_data valid
- lpm_data  out  8  selected program byte
- mem_en  out  1  memory read enable
- mem_addr  out  PROG_MEM_ADDR_WIDTH  memory word address
- mem_data  in  16  memory read data, valid the cycle after mem_en

## Operation

Request rules:
- A requester holds req and a stable addr until gnt.
- A requester may deassert req before it is granted; nothing is issued for it.

Grant decision (combinational, same cycle):
- Only lpm_req: LPM granted.
- Only fetch_req: fetch granted.
- Both requesting: LPM granted, unless streak == LPM_BURST, in which case fetch is granted.
- fetch_gnt and lpm_gnt are never both 1.

Streak counter (4-bit):
- +1 on an LPM grant while fetch_req=1, saturating at LPM_BURST.
- Cleared on a fetch grant, or in any cycle with fetch_req=0.

Memory drive:
- mem_en = fetch_gnt | lpm_gnt.
- mem_addr: fetch_addr[PROG_MEM_ADDR_WIDTH-1:0] on a fetch grant, lpm_addr[PROG_MEM_ADDR_WIDTH:1] on an LPM grant, held at its previous value when idle.

Response FSM (registered):
- States: NONE, RESP_FETCH, RESP_LPM.
- Next state = RESP_FETCH on a fetch grant, RESP_LPM on an LPM grant, NONE otherwise.
- Captured alongside: the byte select (lpm_addr[0]) and an out-of-range flag (word address ≥ PROG_MEM_SIZE).

Response outputs:
- fetch_valid = (state == RESP_FETCH).
- fetch_data = 16'hFFFF when out-of-range, else mem_data.
- lpm_valid = (state == RESP_LPM).
- lpm_data = mem_data[7:0] when byte select is 0, mem_data[15:8] when byte select is 1; 8'hFF when out-of-range.
- When not valid, fetch_data and lpm_data are 0.

## Timing

- Grant: combinational, same cycle as req.
- Data: valid exactly one cycle after the grant; one response per grant, never duplicated.
- Throughput: one access per cycle; back-to-back grants give back-to-back valids with no bubble, including when ownership alternates.
- Reset (rst=0, asynchronous): state NONE, streak 0, mem_addr 0. All of gnt, valid, data, mem_en are 0 while reset is held.
- Reset mid-operation: an in-flight response is dropped; no valid follows reset release.
- First grant possible: the first rising edge after release.
- Address wrap: no wrap into low memory. Out-of-range accesses still pulse mem_en but return the erased value.
- Simultaneous request and response: a new grant in the same cycle as a valid is allowed and required.

## Test plan

1. Reset then fetch_req=1 at addresses 0,1,2 on consecutive cycles with memory preloaded so word[n]=n+16'h1000 -> fetch_gnt=1 each cycle; fetch_valid on the following cycles with data 1000, 1001, 1002.
2. lpm_req with lpm_addr=0x0005, memory word[2]=16'hABCD -> lpm_gnt, mem_addr=2; next cycle lpm_valid=1, lpm_data=0xAB. Repeat with lpm_addr=0x0004 -> lpm_data=0xCD.
3. fetch_req and lpm_req held high for 8 cycles, LPM_BURST=2 -> grant pattern L,L,F,L,L,F,L,L; each valid aligned to the correct port one cycle later.
4. fetch_req=1, fetch_addr=PROG_MEM_SIZE -> fetch_valid next cycle with fetch_data=16'hFFFF. lpm_addr=2*PROG_MEM_SIZE+1 -> lpm_data=8'hFF.
5. Assert rst low asynchronously mid-cycle, one cycle after an LPM grant -> mem_en, lpm_gnt, lpm_valid, fetch_valid drop immediately. No lpm_valid after release. Streak restarts at 0, verified by a fresh L,L,F pattern.
6. lpm_req pulsed with fetch_req=0 for 5 cycles, then both requesting -> streak is 0 at the start, so two LPM grants occur before the first fetch grant.

Source files
------------

// File: rtl/avr_cpu_progmem_arb_if.sv
// Bus bundle between the program-memory arbiter, its two requesters and the memory port.
// The slave modport is the arbiter's view; master is the environment's view.
interface avr_cpu_progmem_arb_if #(
    parameter int AW = 9
);
    logic          fetch_req;
    logic [15:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [15:0]   fetch_data;
    logic          lpm_req;
    logic [15:0]   lpm_addr;
    logic          lpm_gnt;
    logic          lpm_valid;
    logic [7:0]    lpm_data;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;

    modport slave (
        input  fetch_req, fetch_addr, lpm_req, lpm_addr, mem_data,
        output fetch_gnt, fetch_valid, fetch_data,
        output lpm_gnt, lpm_valid, lpm_data, mem_en, mem_addr
    );

    modport master (
        output fetch_req, fetch_addr, lpm_req, lpm_addr, mem_data,
        input  fetch_gnt, fetch_valid, fetch_data,
        input  lpm_gnt, lpm_valid, lpm_data, mem_en, mem_addr
    );
endinterface

// File: rtl/avr_cpu_progmem_arb.sv
// Shares the single-port program memory between instruction fetch (word) and LPM (byte),
// returning each 1-cycle read to its issuer and bounding fetch starvation under LPM bursts.
//
// state      | meaning
// NONE       | no read in flight this cycle
// RESP_FETCH | memory output belongs to the fetch unit
// RESP_LPM   | memory output belongs to the LPM path (byte picked by byte_sel_q)
module avr_cpu_progmem_arb #(
    parameter int PROG_MEM_SIZE       = 512,
    parameter int PROG_MEM_ADDR_WIDTH = $clog2(PROG_MEM_SIZE),
    parameter int LPM_BURST           = 2
) (
    input logic clk,
    input logic rst,
    avr_cpu_progmem_arb_if.slave bus
);
    localparam int AW = PROG_MEM_ADDR_WIDTH;
    localparam logic [3:0]  BURST  = 4'(LPM_BURST);
    localparam logic [16:0] SIZE_W = 17'(PROG_MEM_SIZE);

    typedef enum logic [1:0] {NONE, RESP_FETCH, RESP_LPM} resp_e;

    logic          fetch_gnt;
    logic          lpm_gnt;
    logic [3:0]    streak_q, streak_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    resp_e         state_q, state_d;
    logic          byte_sel_q, byte_sel_d;
    logic          oor_q, oor_d;

    // Grants are masked by reset so nothing is issued while it is held.
    always_comb begin
        lpm_gnt   = rst && bus.lpm_req && !(bus.fetch_req && (streak_q == BURST));
        fetch_gnt = rst && bus.fetch_req && !lpm_gnt;

        streak_d = streak_q;
        if (!bus.fetch_req || fetch_gnt)
            streak_d = 4'd0;
        else if (lpm_gnt && (streak_q != BURST))
            streak_d = streak_q + 4'd1;

        mem_addr_d = mem_addr_q;
        state_d    = NONE;
        byte_sel_d = 1'b0;
        oor_d      = 1'b0;
        if (fetch_gnt) begin
            mem_addr_d = bus.fetch_addr[AW-1:0];
            state_d    = RESP_FETCH;
            oor_d      = ({1'b0, bus.fetch_addr} >= SIZE_W);
        end else if (lpm_gnt) begin
            mem_addr_d = bus.lpm_addr[AW:1];
            state_d    = RESP_LPM;
            byte_sel_d = bus.lpm_addr[0];
            oor_d      = ({2'b00, bus.lpm_addr[15:1]} >= SIZE_W);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q   <= 4'd0;
            mem_addr_q <= '0;
        end else begin
            streak_q   <= streak_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= NONE;
            byte_sel_q <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_sel_q <= byte_sel_d;
            oor_q      <= oor_d;
        end
    end

    assign bus.fetch_gnt = fetch_gnt;
    assign bus.lpm_gnt   = lpm_gnt;
    assign bus.mem_en    = fetch_gnt | lpm_gnt;
    assign bus.mem_addr  = mem_addr_d;

    // Out-of-range reads still hit the memory but report the erased value.
    assign bus.fetch_valid = (state_q == RESP_FETCH);
    assign bus.fetch_data  = !bus.fetch_valid ? 16'h0000 :
                             oor_q            ? 16'hFFFF : bus.mem_data;
    assign bus.lpm_valid   = (state_q == RESP_LPM);
    assign bus.lpm_data    = !bus.lpm_valid   ? 8'h00 :
                             oor_q            ? 8'hFF :
                             byte_sel_q       ? bus.mem_data[15:8] : bus.mem_data[7:0];
endmodule

// File: tb/tb_avr_cpu_progmem_arb.sv
// Directed scenarios plus random traffic against a cycle-level reference model of the arbiter.
module tb_avr_cpu_progmem_arb;
    localparam int SIZE  = 512;
    localparam int AW    = 9;
    localparam int BURST = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    avr_cpu_progmem_arb_if #(.AW(AW)) bus();

    avr_cpu_progmem_arb #(
        .PROG_MEM_SIZE(SIZE),
        .PROG_MEM_ADDR_WIDTH(AW),
        .LPM_BURST(BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] mem [0:SIZE-1];
    always @(posedge clk)
        if (bus.mem_en) bus.mem_data <= mem[bus.mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model state
    int          m_streak;
    logic [8:0]  m_addr;
    logic        m_fv, m_lv, m_fg, m_lg;
    logic [15:0] m_fd;
    logic [7:0]  m_ld;
    // last observed DUT values
    logic        o_fgnt, o_lgnt, o_men;
    logic [8:0]  o_maddr;
    logic [15:0] o_fd;
    logic [7:0]  o_ld;

    function automatic logic [15:0] fetch_ref(input logic [15:0] a);
        if (int'(a) >= SIZE) return 16'hFFFF;
        return mem[int'(a)];
    endfunction

    function automatic logic [7:0] lpm_ref(input logic [15:0] z);
        int w;
        logic [15:0] word;
        w = int'(z) / 2;
        if (w >= SIZE) return 8'hFF;
        word = mem[w];
        return (z % 2 == 1) ? word[15:8] : word[7:0];
    endfunction

    task automatic model_reset();
        m_streak = 0; m_addr = '0;
        m_fv = 0; m_lv = 0; m_fd = '0; m_ld = '0; m_fg = 0; m_lg = 0;
    endtask

    // Called at posedge+1 with inputs set; checks at negedge, returns at next posedge+1.
    task automatic tick();
        logic [8:0] ea;
        @(negedge clk);
        m_lg = bus.lpm_req && !(bus.fetch_req && m_streak == BURST);
        m_fg = bus.fetch_req && !m_lg;
        ea = m_fg ? bus.fetch_addr[8:0] : (m_lg ? bus.lpm_addr[9:1] : m_addr);
        o_fgnt = bus.fetch_gnt; o_lgnt = bus.lpm_gnt; o_men = bus.mem_en;
        o_maddr = bus.mem_addr; o_fd = bus.fetch_data; o_ld = bus.lpm_data;
        check("fetch_gnt", 16'(bus.fetch_gnt), 16'(m_fg));
        check("lpm_gnt", 16'(bus.lpm_gnt), 16'(m_lg));
        check("mem_en", 16'(bus.mem_en), 16'(m_fg | m_lg));
        check("mem_addr", 16'(bus.mem_addr), 16'(ea));
        check("fetch_valid", 16'(bus.fetch_valid), 16'(m_fv));
        check("fetch_data", bus.fetch_data, m_fd);
        check("lpm_valid", 16'(bus.lpm_valid), 16'(m_lv));
        check("lpm_data", 16'(bus.lpm_data), 16'(m_ld));
        m_fv = m_fg; m_fd = m_fg ? fetch_ref(bus.fetch_addr) : 16'h0;
        m_lv = m_lg; m_ld = m_lg ? lpm_ref(bus.lpm_addr) : 8'h0;
        if (!bus.fetch_req || m_fg) m_streak = 0;
        else if (m_lg && m_streak < BURST) m_streak++;
        m_addr = ea;
        @(posedge clk); #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"}, 16'({bus.fetch_gnt, bus.lpm_gnt}), 16'h0);
        check({tag, "_mem_en"}, 16'(bus.mem_en), 16'h0);
        check({tag, "_valid"}, 16'({bus.fetch_valid, bus.lpm_valid}), 16'h0);
        check({tag, "_data"}, bus.fetch_data | 16'(bus.lpm_data), 16'h0);
        check({tag, "_mem_addr"}, 16'(bus.mem_addr), 16'h0);
    endtask

    task automatic set_req(input logic f, input logic [15:0] fa, input logic l, input logic [15:0] la);
        bus.fetch_req = f; bus.fetch_addr = fa; bus.lpm_req = l; bus.lpm_addr = la;
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b11011011;
        for (int i = 0; i < SIZE; i++) mem[i] = 16'(i) + 16'h1000;
        rst = 1'b0;
        set_req(1, 16'h0, 1, 16'h0);
        repeat (2) @(posedge clk);
        #2 check_quiet("reset");
        @(negedge clk);
        set_req(0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();

        // sequential fetches
        set_req(1, 16'd0, 0, 0); tick();
        check("t1_gnt0", 16'(o_fgnt), 16'h1);
        set_req(1, 16'd1, 0, 0); tick();
        check("t1_data0", o_fd, 16'h1000);
        set_req(1, 16'd2, 0, 0); tick();
        check("t1_data1", o_fd, 16'h1001);
        set_req(0, 0, 0, 0); tick();
        check("t1_data2", o_fd, 16'h1002);

        // LPM byte select
        mem[2] = 16'hABCD;
        set_req(0, 0, 1, 16'h0005); tick();
        check("t2_maddr", 16'(o_maddr), 16'h2);
        set_req(0, 0, 1, 16'h0004); tick();
        check("t2_hi", 16'(o_ld), 16'h00AB);
        set_req(0, 0, 0, 0); tick();
        check("t2_lo", 16'(o_ld), 16'h00CD);

        // out-of-range
        set_req(1, 16'(SIZE), 0, 0); tick();
        check("t4_mem_en", 16'(o_men), 16'h1);
        set_req(0, 0, 1, 16'(2*SIZE+1)); tick();
        check("t4_fetch_ff", o_fd, 16'hFFFF);
        set_req(0, 0, 0, 0); tick();
        check("t4_lpm_ff", 16'(o_ld), 16'h00FF);

        // contention pattern
        for (int i = 0; i < 8; i++) begin
            set_req(1, 16'(20 + i), 1, 16'(100 + i)); tick();
            check("t3_pattern", 16'(o_lgnt), 16'(pat[7-i]));
        end
        set_req(0, 0, 1, 16'h0031); tick();

        // async reset right after an LPM grant
        set_req(1, 16'h7, 1, 16'h9);
        #2 rst = 1'b0;
        #1 check_quiet("t5_async");
        @(negedge clk);
        check_quiet("t5_held");
        set_req(0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(1, 16'(40 + i), 1, 16'(200 + i)); tick();
            check("t5_pattern", 16'(o_lgnt), 16'(pat[7-i]));
        end

        // LPM alone leaves the streak at zero
        for (int i = 0; i < 5; i++) begin
            set_req(0, 0, (i % 2 == 0), 16'(300 + i)); tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_req(1, 16'(50 + i), 1, 16'(400 + i)); tick();
            check("t6_pattern", 16'(o_lgnt), 16'(pat[7-i]));
        end

        // random traffic
        for (int i = 0; i < SIZE; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 2000; i++) begin
            if (!bus.fetch_req || m_fg) begin
                bus.fetch_req  = ($urandom_range(0, 3) != 0);
                bus.fetch_addr = 16'($urandom_range(0, 600));
            end else if ($urandom_range(0, 15) == 0) bus.fetch_req = 1'b0;
            if (!bus.lpm_req || m_lg) begin
                bus.lpm_req  = ($urandom_range(0, 2) != 0);
                bus.lpm_addr = 16'($urandom_range(0, 1100));
            end else if ($urandom_range(0, 15) == 0) bus.lpm_req = 1'b0;
            tick();
        end
        set_req(0, 0, 0, 0); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
